// File: rtl/axi_lite_pmem_bridge.sv
// rtl/axi_lite_pmem_bridge.sv - AXI4-Lite slave that turns each transaction into one pmem strobe
//
// Ports:
//   clock, reset              clock and asynchronous active-low reset
//   arvalid/arready/araddr    read address channel
//   rvalid/rready/rdata/rresp read data channel (rresp always OKAY)
//   awvalid/awready/awaddr    write address channel
//   wvalid/wready/wdata/wstrb write data channel
//   bvalid/bready/bresp       write response channel (bresp always OKAY)
//   mem_rvalid/mem_raddr      one-cycle read strobe and address to pmem
//   mem_rdata                 pmem read data, valid while mem_rvalid is high
//   mem_wvalid/mem_waddr/
//   mem_wdata/mem_mask        one-cycle write strobe, address, data and byte mask to pmem

module axi_lite_pmem_bridge #(
   parameter int RD_LAT = 1,
   parameter int WR_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        arvalid,
   output logic        arready,
   input  logic [63:0] araddr,
   output logic        rvalid,
   input  logic        rready,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   input  logic        awvalid,
   output logic        awready,
   input  logic [63:0] awaddr,
   input  logic        wvalid,
   output logic        wready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic        mem_rvalid,
   output logic [63:0] mem_raddr,
   input  logic [63:0] mem_rdata,
   output logic        mem_wvalid,
   output logic [63:0] mem_waddr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_mask
);

   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   localparam logic [CW-1:0] RD_CNT0 = CW'(RD_LAT - 1);
   localparam logic [CW-1:0] WR_CNT0 = CW'(WR_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_RESP,
      WR_WAIT,
      WR_RESP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic          aw_held;
   logic [63:0]   awaddr_q;
   logic          w_held;
   logic [63:0]   wdata_q;
   logic [7:0]    wstrb_q;

   logic          wr_busy;
   logic          aw_take;
   logic          w_take;
   logic          ar_take;
   logic          pair_now;
   logic [63:0]   waddr_n;
   logic [63:0]   wdata_n;
   logic [7:0]    wmask_n;

   assign wr_busy  = (state == WR_WAIT) || (state == WR_RESP);
   assign awready  = !aw_held && !wr_busy;
   assign wready   = !w_held && !wr_busy;
   // A fully held write pair blocks new reads so the write goes first.
   assign arready  = (state == IDLE) && !(aw_held && w_held);

   assign aw_take  = awvalid && awready;
   assign w_take   = wvalid && wready;
   assign ar_take  = arvalid && arready;

   // Pair is complete if each half is either already held or arriving this cycle,
   // so the write can start on the very edge that completes it.
   assign pair_now = (aw_held || aw_take) && (w_held || w_take);
   assign waddr_n  = aw_held ? awaddr_q : awaddr;
   assign wdata_n  = w_held  ? wdata_q  : wdata;
   assign wmask_n  = w_held  ? wstrb_q  : wstrb;

   assign rresp    = 2'b00;
   assign bresp    = 2'b00;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         aw_held    <= 1'b0;
         awaddr_q   <= '0;
         w_held     <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rvalid     <= 1'b0;
         rdata      <= '0;
         bvalid     <= 1'b0;
         mem_rvalid <= 1'b0;
         mem_raddr  <= '0;
         mem_wvalid <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         mem_mask   <= '0;
      end else begin
         // Strobes are single-cycle pulses unless re-armed below.
         mem_rvalid <= 1'b0;
         mem_wvalid <= 1'b0;

         if (aw_take) begin
            aw_held  <= 1'b1;
            awaddr_q <= awaddr;
         end
         if (w_take) begin
            w_held  <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
         end

         case (state)
            IDLE: begin
               // ar_take can only be true when no complete pair is already held;
               // a read accepted on the edge a pair completes still wins.
               if (ar_take) begin
                  state      <= RD_WAIT;
                  cnt        <= RD_CNT0;
                  mem_raddr  <= araddr;
                  mem_rvalid <= (RD_LAT == 1);
               end else if (pair_now) begin
                  state      <= WR_WAIT;
                  cnt        <= WR_CNT0;
                  mem_waddr  <= waddr_n;
                  mem_wdata  <= wdata_n;
                  mem_mask   <= wmask_n;
                  mem_wvalid <= (WR_LAT == 1);
               end
            end
            RD_WAIT: begin
               if (cnt == '0) begin
                  rdata  <= mem_rdata;
                  rvalid <= 1'b1;
                  state  <= RD_RESP;
               end else begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) mem_rvalid <= 1'b1;
               end
            end
            RD_RESP: begin
               if (rready) begin
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            WR_WAIT: begin
               if (cnt == '0) begin
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  bvalid  <= 1'b1;
                  state   <= WR_RESP;
               end else begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) mem_wvalid <= 1'b1;
               end
            end
            WR_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
